// File: rtl/fc_pkg.sv
// Shared types for the FreeCell rules engine: card encoding, location classes
// and the game-phase state machine encoding.
package fc_pkg;

    localparam logic [1:0] SUIT_CLUBS    = 2'd0;
    localparam logic [1:0] SUIT_DIAMONDS = 2'd1;
    localparam logic [1:0] SUIT_HEARTS   = 2'd2;
    localparam logic [1:0] SUIT_SPADES   = 2'd3;

    localparam logic [3:0] RANK_ACE  = 4'd1;
    localparam logic [3:0] RANK_KING = 4'd13;

    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_t;

    typedef enum logic [1:0] {LOC_COL, LOC_CELL, LOC_HOME} loc_t;

    typedef enum logic [1:0] {ST_LOAD, ST_PLAY, ST_WON} state_t;

    function automatic logic is_red(input card_t c);
        return c.suit[1] ^ c.suit[0];
    endfunction

endpackage

// File: rtl/fc_move_check.sv
// Combinational legality check for one single-card move, given the moving
// card and everything known about the destination.
module fc_move_check
    import fc_pkg::*;
(
    input  card_t      card,
    input  card_t      dst_top,
    input  logic       dst_occ,
    input  logic       dst_full,
    input  logic [3:0] found_rank,
    input  loc_t       src_cls,
    input  loc_t       dst_cls,
    input  logic       same_loc,
    output logic       legal
);

    always_comb begin
        legal = 1'b0;
        // An empty source carries rank 0, so it can never be legal.
        if (src_cls != LOC_HOME && card.rank != 4'd0 && !same_loc) begin
            case (dst_cls)
                LOC_COL:  legal = !dst_full &&
                                  (!dst_occ ||
                                   (dst_top.rank == card.rank + 4'd1 &&
                                    is_red(dst_top) != is_red(card)));
                LOC_CELL: legal = !dst_occ;
                default:  legal = (found_rank == card.rank - 4'd1);
            endcase
        end
    end

endmodule

// File: rtl/freecell_engine.sv
// FreeCell rules engine: holds tableau, free cells and foundations, accepts a
// deal in the load phase and then checks and applies one move per cycle.
module freecell_engine
    import fc_pkg::*;
#(
    parameter int NUM_COLS  = 8,
    parameter int NUM_CELLS = 4,
    parameter int DEPTH     = 20,
    parameter int POS_W     = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [POS_W-1:0] load_col,
    input  logic [5:0]       load_card,
    input  logic             start,
    input  logic             move_valid,
    input  logic [POS_W-1:0] source,
    input  logic [POS_W-1:0] dest,
    output logic             move_done,
    output logic             move_ok,
    output logic             load_err,
    output logic [CNT_W-1:0] move_count,
    output logic             win
);

    localparam int HW   = $clog2(DEPTH + 1);
    localparam int NLOC = NUM_COLS + NUM_CELLS;

    state_t        state, state_nxt;
    card_t         col_mem [NUM_COLS][DEPTH];
    logic [HW-1:0] height  [NUM_COLS];
    card_t         cells   [NUM_CELLS];
    logic [3:0]    found   [4];

    function automatic loc_t classify(input logic [POS_W-1:0] code);
        if (int'(code) < NUM_COLS) return LOC_COL;
        if (int'(code) < NLOC)     return LOC_CELL;
        return LOC_HOME;
    endfunction

    loc_t             src_cls, dst_cls;
    card_t            src_card, dst_top, in_card, wr_card;
    logic             dst_occ, dst_full, same_loc, legal, load_full;
    logic             accept, do_move, do_load, load_bad, won_now, wr_en;
    logic [3:0]       found_rank;
    logic [POS_W-1:0] wr_col;

    assign in_card  = card_t'(load_card);
    assign src_cls  = classify(source);
    assign dst_cls  = classify(dest);
    assign same_loc = (source == dest);

    always_comb begin
        src_card  = '0;
        dst_top   = '0;
        dst_occ   = 1'b0;
        dst_full  = 1'b0;
        load_full = 1'b0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (int'(source) == i && height[i] != '0)
                src_card = col_mem[i][height[i] - 1'b1];
            if (int'(dest) == i) begin
                dst_occ  = (height[i] != '0);
                dst_full = (int'(height[i]) == DEPTH);
                if (height[i] != '0)
                    dst_top = col_mem[i][height[i] - 1'b1];
            end
            if (int'(load_col) == i)
                load_full = (int'(height[i]) == DEPTH);
        end
        for (int j = 0; j < NUM_CELLS; j++) begin
            if (int'(source) == NUM_COLS + j)
                src_card = cells[j];
            if (int'(dest) == NUM_COLS + j)
                dst_occ = (cells[j].rank != 4'd0);
        end
    end

    assign found_rank = found[src_card.suit];

    fc_move_check u_check (
        .card       (src_card),
        .dst_top    (dst_top),
        .dst_occ    (dst_occ),
        .dst_full   (dst_full),
        .found_rank (found_rank),
        .src_cls    (src_cls),
        .dst_cls    (dst_cls),
        .same_loc   (same_loc),
        .legal      (legal)
    );

    assign accept   = move_valid && state != ST_LOAD;
    assign do_move  = move_valid && state == ST_PLAY && legal;
    assign load_bad = int'(load_col) >= NUM_COLS || load_full ||
                      in_card.rank < RANK_ACE || in_card.rank > RANK_KING;
    assign do_load  = load_valid && state == ST_LOAD && !load_bad;

    // The game is won by a legal king-to-home move when every other suit is complete.
    always_comb begin
        won_now = do_move && dst_cls == LOC_HOME && src_card.rank == RANK_KING;
        for (int s = 0; s < 4; s++) begin
            if (found[s] != RANK_KING && src_card.suit != 2'(s))
                won_now = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: if (start)   state_nxt = ST_PLAY;
            ST_PLAY: if (won_now) state_nxt = ST_WON;
            default:              state_nxt = state;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_col  = load_col;
        wr_card = in_card;
        if (do_load) begin
            wr_en = 1'b1;
        end else if (do_move && dst_cls == LOC_COL) begin
            wr_en   = 1'b1;
            wr_col  = dest;
            wr_card = src_card;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_LOAD;
            move_done  <= 1'b0;
            move_ok    <= 1'b0;
            load_err   <= 1'b0;
            move_count <= '0;
            for (int i = 0; i < NUM_COLS; i++)  height[i] <= '0;
            for (int j = 0; j < NUM_CELLS; j++) cells[j]  <= '0;
            for (int s = 0; s < 4; s++)         found[s]  <= '0;
        end else begin
            state     <= state_nxt;
            move_done <= accept;
            move_ok   <= do_move;
            load_err  <= load_valid && state == ST_LOAD && load_bad;
            if (do_move && move_count != '1)
                move_count <= move_count + 1'b1;
            for (int i = 0; i < NUM_COLS; i++) begin
                if (wr_en && int'(wr_col) == i)
                    height[i] <= height[i] + 1'b1;
                else if (do_move && src_cls == LOC_COL && int'(source) == i)
                    height[i] <= height[i] - 1'b1;
            end
            for (int j = 0; j < NUM_CELLS; j++) begin
                if (do_move && dst_cls == LOC_CELL && int'(dest) == NUM_COLS + j)
                    cells[j] <= src_card;
                else if (do_move && src_cls == LOC_CELL && int'(source) == NUM_COLS + j)
                    cells[j] <= '0;
            end
            if (do_move && dst_cls == LOC_HOME)
                found[src_card.suit] <= found[src_card.suit] + 1'b1;
        end
    end

    // Card storage is data only; slots above a column's height are never read.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_COLS; i++) begin
            if (wr_en && int'(wr_col) == i)
                col_mem[i][height[i]] <= wr_card;
        end
    end

    assign win = (state == ST_WON);

endmodule

// File: tb/tb_freecell_engine.sv
// Bench for freecell_engine: directed move table, full-game and load-limit
// sequences, then random play against a queue-based model of the game rules.
module tb_freecell_engine;

    localparam int NC    = 8;
    localparam int NCELL = 4;
    localparam int DEPTH = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load_valid = 1'b0;
    logic [3:0] load_col = '0;
    logic [5:0] load_card = '0;
    logic       start = 1'b0;
    logic       move_valid = 1'b0;
    logic [3:0] source = '0;
    logic [3:0] dest = '0;
    logic       move_done, move_ok, load_err, win;
    logic [7:0] move_count;

    always #5 clock = ~clock;

    freecell_engine dut (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_col   (load_col),
        .load_card  (load_card),
        .start      (start),
        .move_valid (move_valid),
        .source     (source),
        .dest       (dest),
        .move_done  (move_done),
        .move_ok    (move_ok),
        .load_err   (load_err),
        .move_count (move_count),
        .win        (win)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- game model: columns as queues, cards as suit*16+rank
    int col_q[NC][$];
    int cell_m[NCELL];
    int fnd[4];
    int m_cnt;
    int m_phase;   // 0 load, 1 play, 2 won

    function automatic int cd(input int suit, input int rank);
        return suit * 16 + rank;
    endfunction
    function automatic int rk(input int c); return c % 16; endfunction
    function automatic int su(input int c); return c / 16; endfunction
    function automatic bit red(input int c);
        return su(c) == 1 || su(c) == 2;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) col_q[i].delete();
        for (int j = 0; j < NCELL; j++) cell_m[j] = 0;
        for (int s = 0; s < 4; s++) fnd[s] = 0;
        m_cnt = 0;
        m_phase = 0;
    endfunction

    function automatic bit model_load(input int col, input int card);
        if (m_phase != 0) return 0;
        if (col >= NC || rk(card) < 1 || rk(card) > 13) return 1;
        if (col_q[col].size() >= DEPTH) return 1;
        col_q[col].push_back(card);
        return 0;
    endfunction

    function automatic bit model_move(input int s, input int d);
        int c;
        int t;
        bit all_done;
        if (m_phase != 1) return 0;
        if (s < NC) begin
            if (col_q[s].size() == 0) return 0;
            c = col_q[s][$];
        end else if (s < NC + NCELL) begin
            c = cell_m[s - NC];
            if (c == 0) return 0;
        end else return 0;
        if (s == d) return 0;
        if (d < NC) begin
            if (col_q[d].size() >= DEPTH) return 0;
            if (col_q[d].size() > 0) begin
                t = col_q[d][$];
                if (rk(t) != rk(c) + 1 || red(t) == red(c)) return 0;
            end
        end else if (d < NC + NCELL) begin
            if (cell_m[d - NC] != 0) return 0;
        end else if (fnd[su(c)] != rk(c) - 1) return 0;
        if (s < NC) void'(col_q[s].pop_back());
        else cell_m[s - NC] = 0;
        if (d < NC) col_q[d].push_back(c);
        else if (d < NC + NCELL) cell_m[d - NC] = c;
        else fnd[su(c)]++;
        if (m_cnt < 255) m_cnt++;
        all_done = 1;
        for (int k = 0; k < 4; k++) if (fnd[k] != 13) all_done = 0;
        if (all_done) m_phase = 2;
        return 1;
    endfunction

    // ---------------- drivers
    task automatic do_reset();
        @(negedge clock);
        reset = 1; load_valid = 0; start = 0; move_valid = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 0;
        model_reset();
    endtask

    task automatic load(input int col, input int card, input string nm);
        bit e;
        @(negedge clock);
        load_valid = 1; load_col = 4'(col); load_card = 6'(card);
        @(posedge clock); #1;
        load_valid = 0;
        e = model_load(col, card);
        chk(nm, int'(load_err), int'(e));
    endtask

    task automatic go();
        @(negedge clock);
        start = 1;
        @(posedge clock); #1;
        start = 0;
        if (m_phase == 0) m_phase = 1;
    endtask

    // exp_ok < 0 means take the expectation from the model
    task automatic mv(input int s, input int d, input int exp_ok, input string nm);
        bit m;
        @(negedge clock);
        move_valid = 1; source = 4'(s); dest = 4'(d);
        @(posedge clock); #1;
        move_valid = 0;
        m = model_move(s, d);
        chk({nm, " done"},  int'(move_done), 1);
        chk({nm, " ok"},    int'(move_ok), (exp_ok < 0) ? int'(m) : exp_ok);
        chk({nm, " count"}, int'(move_count), m_cnt);
        chk({nm, " win"},   int'(win), int'(m_phase == 2));
    endtask

    typedef struct {
        int src;
        int dst;
        int ok;
    } mv_vec_t;

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : main
        mv_vec_t tbl [19];
        int k;
        tbl = '{
            '{0, 12, 1},   // A-hearts home
            '{0, 12, 0},   // 5-clubs onto empty clubs foundation
            '{2, 1, 0},    // 5-hearts onto 6-diamonds, same colour
            '{2, 3, 1},    // 5-hearts to empty column
            '{2, 1, 1},    // 5-spades onto 6-diamonds
            '{1, 2, 1},    // 5-spades back to empty column
            '{4, 8, 1},
            '{4, 9, 1},
            '{4, 10, 1},
            '{4, 11, 1},
            '{0, 8, 0},    // cell occupied
            '{8, 4, 1},    // cell to empty column
            '{12, 3, 0},   // home as source
            '{5, 12, 0},   // empty column source
            '{0, 0, 0},    // source == dest
            '{9, 9, 0},    // cell onto itself
            '{11, 15, 0},  // 2-clubs home without ace
            '{2, 1, 1},    // 5-spades onto 6-diamonds again
            '{10, 1, 0}    // 3-clubs onto 5-spades
        };

        // reset state
        model_reset();
        do_reset();
        chk("reset move_done",  int'(move_done), 0);
        chk("reset move_ok",    int'(move_ok), 0);
        chk("reset load_err",   int'(load_err), 0);
        chk("reset move_count", int'(move_count), 0);
        chk("reset win",        int'(win), 0);

        // directed deal and move table
        load(0, cd(0, 5), "ld"); load(0, cd(2, 1), "ld");
        load(1, cd(1, 6), "ld");
        load(2, cd(3, 5), "ld"); load(2, cd(2, 5), "ld");
        load(4, cd(0, 2), "ld"); load(4, cd(0, 3), "ld");
        load(4, cd(0, 4), "ld"); load(4, cd(0, 7), "ld");
        go();
        for (int i = 0; i < 19; i++)
            mv(tbl[i].src, tbl[i].dst, tbl[i].ok, $sformatf("vec%0d", i));
        chk("directed count", int'(move_count), 10);
        load(2, cd(0, 0), "load ignored in play");

        // full game: one suit per column, ace on top, plus a spare card
        do_reset();
        for (int s = 0; s < 4; s++)
            for (int r = 13; r >= 1; r--) load(s, cd(s, r), "deal52");
        load(4, cd(0, 5), "deal52 spare");
        go();
        k = 0;
        for (int r = 1; r <= 13; r++)
            for (int s = 0; s < 4; s++) begin
                k++;
                mv(s, 12 + (k % 4), 1, $sformatf("home%0d", k));
            end
        chk("game count", int'(move_count), 52);
        chk("game win",   int'(win), 1);
        mv(4, 8, 0, "move after win");
        chk("win holds", int'(win), 1);

        // load limits, start+load in one cycle, reset mid-play
        do_reset();
        for (int i = 0; i < DEPTH; i++) load(0, cd(i % 4, i % 13 + 1), "fill");
        load(0, cd(0, 1), "overflow");
        chk("overflow flagged", int'(load_err), 1);
        load(8, cd(1, 3), "bad col");
        load(1, cd(1, 0), "rank0");
        load(1, cd(1, 14), "rank14");
        @(negedge clock);
        load_valid = 1; load_col = 4'd1; load_card = 6'(cd(2, 13)); start = 1;
        @(posedge clock); #1;
        load_valid = 0; start = 0;
        chk("start+load err", int'(load_err), int'(model_load(1, cd(2, 13))));
        m_phase = 1;
        mv(1, 8, 1, "king to cell");
        mv(0, 9, 1, "col0 to cell");
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
        model_reset();
        chk("midreset move_done",  int'(move_done), 0);
        chk("midreset move_ok",    int'(move_ok), 0);
        chk("midreset load_err",   int'(load_err), 0);
        chk("midreset move_count", int'(move_count), 0);
        chk("midreset win",        int'(win), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            move_valid = 1; source = 4'd8; dest = 4'd0;
            @(posedge clock); #1;
            move_valid = 0;
            chk("no move in load", int'(move_done), 0);
        end
        load(0, cd(1, 1), "post reset load");
        go();
        mv(8, 0, 0, "cell emptied by reset");
        mv(0, 14, 1, "ace home after reset");

        // random deal and play against the model
        do_reset();
        for (int i = 0; i < 80; i++)
            load($urandom_range(0, 9), cd($urandom_range(0, 3), $urandom_range(0, 15)), "rand load");
        go();
        for (int i = 0; i < 600; i++) begin
            int s;
            int d;
            s = $urandom_range(0, 12);
            d = ($urandom_range(0, 2) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 15);
            mv(s, d, -1, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
